traceback_prefetch_window_engine: RTL and testbench

TRACEBACK_PREFETCH_WINDOW_ENGINE -- requirements
Module: traceback_prefetch_window_engine

---
 rtl/traceback_prefetch_window_engine_if.sv | 72 +++++++
 rtl/traceback_prefetch_window_engine.sv | 168 ++++++++++++++++
 tb/tb_traceback_prefetch_window_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traceback_prefetch_window_engine_if.sv
// Bus bundle for the traceback prefetch window engine: column loading,
// window requests and window delivery.
//
// Handshake semantics (both req_* and out_*): a transfer happens on a rising
// edge where valid and ready are both high. Once raised, valid and its payload
// stay unchanged until that transfer. Ready may depend on valid of the same
// channel only through registered state, never combinationally on it, so
// there are no combinational loops through either channel.
interface traceback_prefetch_window_engine_if #(
    parameter int N               = 16,
    parameter int DIRECTION_WIDTH = 5,
    parameter int PREFETCH_LENGTH = 8,
    parameter int POSITION_WIDTH  = 10
) ();

    // Column bank control and data
    logic                                     flush;
    logic                                     col_valid;
    logic [N*DIRECTION_WIDTH-1:0]             col_k0;
    logic [N*DIRECTION_WIDTH-1:0]             col_k1;

    // Window request channel
    logic                                     req_valid;
    logic                                     req_ready;
    logic [1:0]                               req_mode;
    logic [POSITION_WIDTH-1:0]                in_block_x_startpoint;
    logic [POSITION_WIDTH-1:0]                prefetch_x_startpoint;

    // Window delivery channel
    logic                                     out_valid;
    logic                                     out_ready;
    logic [PREFETCH_LENGTH*DIRECTION_WIDTH-1:0] out_window;
    logic                                     out_sel;
    logic [3:0]                               out_epoch;

    // Side that issues columns and requests and consumes windows
    modport master (
        output flush,
        output col_valid,
        output col_k0,
        output col_k1,
        output req_valid,
        input  req_ready,
        output req_mode,
        output in_block_x_startpoint,
        output prefetch_x_startpoint,
        input  out_valid,
        output out_ready,
        input  out_window,
        input  out_sel,
        input  out_epoch
    );

    // Engine side
    modport slave (
        input  flush,
        input  col_valid,
        input  col_k0,
        input  col_k1,
        input  req_valid,
        output req_ready,
        input  req_mode,
        input  in_block_x_startpoint,
        input  prefetch_x_startpoint,
        output out_valid,
        input  out_ready,
        output out_window,
        output out_sel,
        output out_epoch
    );

endinterface

// File: rtl/traceback_prefetch_window_engine.sv
// Traceback prefetch window engine.
//
// Holds one pair of direction columns (current k0, preceding k1) and, per
// accepted request, cuts a PREFETCH_LENGTH-entry window ending at the selected
// startpoint out of the virtual sequence formed by k1 followed by k0. The
// window, the startpoint selector and the column-pair epoch are registered
// and offered on a valid/ready output with one cycle of latency.
//
// Control state:
//   EMPTY - no column pair loaded, requests stall
//   IDLE  - column pair loaded, output register empty
//   BUSY  - output register holds a window awaiting out_ready
// col_loaded and out_valid are both decoded from this single state register.
module traceback_prefetch_window_engine #(
    parameter int N               = 16,
    parameter int DIRECTION_WIDTH = 5,
    parameter int PREFETCH_LENGTH = 8,
    parameter int POSITION_WIDTH  = 10
) (
    input  logic clk,
    input  logic rst_n,
    traceback_prefetch_window_engine_if.slave if_bus,
    output logic [1:0] o_dbg_state
);

    localparam int SW = $clog2(N);
    localparam int DW = DIRECTION_WIDTH;
    localparam int L  = PREFETCH_LENGTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Column bank
    logic [N*DW-1:0]       r_k0;
    logic [N*DW-1:0]       r_k1;
    logic [3:0]            r_epoch;

    // Output register
    logic [L*DW-1:0]       r_win;
    logic                  r_sel;
    logic [3:0]            r_out_epoch;

    // Decoded control
    logic                  w_col_loaded;
    logic                  w_out_valid;
    logic                  w_req_ready;
    logic                  w_accept;

    // Window selection datapath
    logic                  w_sel;
    logic [POSITION_WIDTH-1:0] w_start;
    logic [SW-1:0]         w_s;
    logic [2*N*DW-1:0]     w_v;
    logic [L*DW-1:0]       w_win;
    logic                  w_unused_start;

    // Decode handshake control from the state register
    always_comb begin
        w_col_loaded = (r_state != ST_EMPTY);
        w_out_valid  = (r_state == ST_BUSY);
        w_req_ready  = w_col_loaded && (!w_out_valid || if_bus.out_ready) && !if_bus.flush;
        w_accept     = if_bus.req_valid && w_req_ready;
    end

    // Next-state logic: flush dominates, a same-cycle column load keeps the bank usable
    always_comb begin
        w_state_nxt = r_state;
        if (if_bus.flush) begin
            w_state_nxt = if_bus.col_valid ? ST_IDLE : ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (if_bus.col_valid) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_BUSY;
                    end else if (if_bus.out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Column bank: a new pair replaces the old one and bumps the epoch; flush leaves data and epoch alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k0    <= '0;
            r_k1    <= '0;
            r_epoch <= 4'd0;
        end else if (if_bus.col_valid) begin
            r_k0    <= if_bus.col_k0;
            r_k1    <= if_bus.col_k1;
            r_epoch <= r_epoch + 4'd1;
        end
    end

    // Startpoint selection: only mode 2'b10 picks the prefetch startpoint
    always_comb begin
        w_sel   = (if_bus.req_mode == 2'b10);
        w_start = w_sel ? if_bus.prefetch_x_startpoint : if_bus.in_block_x_startpoint;
        w_s     = w_start[SW-1:0];
    end

    // Upper startpoint bits are intentionally ignored
    assign w_unused_start = ^w_start;

    // Virtual sequence: entry j of w_v is V[j-N], so k1 occupies the low half and k0 the high half
    assign w_v = {r_k0, r_k1};

    // Window entry e is V[s-(L-1)+e], i.e. w_v entry s+N-(L-1)+e; entry 0 lands in the top DW bits
    for (genvar e = 0; e < L; e++) begin : g_win
        localparam int OFF = N - (L - 1) + e;
        logic [SW:0] w_idx;
        assign w_idx = {1'b0, w_s} + OFF[SW:0];
        assign w_win[(L-1-e)*DW +: DW] = w_v[w_idx*DW +: DW];
    end

    // Output register loads on acceptance from the bank as it stood before this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_sel       <= 1'b0;
            r_out_epoch <= 4'd0;
        end else if (w_accept) begin
            r_win       <= w_win;
            r_sel       <= w_sel;
            r_out_epoch <= r_epoch;
        end
    end

    // Drive the bus outputs
    always_comb begin
        if_bus.req_ready  = w_req_ready;
        if_bus.out_valid  = w_out_valid;
        if_bus.out_window = r_win;
        if_bus.out_sel    = r_sel;
        if_bus.out_epoch  = r_out_epoch;
        o_dbg_state       = r_state;
    end

endmodule

// File: tb/tb_traceback_prefetch_window_engine.sv
// Testbench for traceback_prefetch_window_engine: directed vector table,
// hand-written multi-cycle sequences, then randomized traffic against a
// behavioural model with an expected-window queue.
module tb_traceback_prefetch_window_engine;

    localparam int N  = 16;
    localparam int DW = 5;
    localparam int L  = 8;
    localparam int PW = 10;
    localparam int WW = L * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] unused_dbg_state;

    always #5 clk = ~clk;

    traceback_prefetch_window_engine_if #(
        .N(N), .DIRECTION_WIDTH(DW), .PREFETCH_LENGTH(L), .POSITION_WIDTH(PW)
    ) u_if ();

    traceback_prefetch_window_engine #(
        .N(N), .DIRECTION_WIDTH(DW), .PREFETCH_LENGTH(L), .POSITION_WIDTH(PW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_bus      (u_if),
        .o_dbg_state (unused_dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        u_if.flush = 1'b0;
        u_if.col_valid = 1'b0;
        u_if.req_valid = 1'b0;
        u_if.req_mode = 2'b00;
        u_if.in_block_x_startpoint = '0;
        u_if.prefetch_x_startpoint = '0;
        u_if.out_ready = 1'b0;
    endtask

    // pattern 0: k0[i]=i, k1[i]=16+i ; pattern 1: k0[i]=31-i, k1[i]=i
    task automatic set_cols(input logic pat);
        for (int i = 0; i < N; i++) begin
            u_if.col_k0[i*DW +: DW] = pat ? DW'(31 - i) : DW'(i);
            u_if.col_k1[i*DW +: DW] = pat ? DW'(i) : DW'(16 + i);
        end
    endtask

    function automatic logic [WW-1:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
        return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5), DW'(a6), DW'(a7)};
    endfunction

    task automatic do_reset();
        idle_inputs();
        set_cols(1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            col_valid;
        logic            col_pat;
        logic            flush;
        logic            req_valid;
        logic [1:0]      mode;
        logic [PW-1:0]   inblk;
        logic [PW-1:0]   pf;
        logic            out_ready;
        logic            exp_rr;
        logic            exp_ov;
        logic [WW-1:0]   exp_win;
        logic            exp_sel;
        logic [3:0]      exp_ep;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    // ---------------- model / scoreboard ----------------
    logic            m_loaded;
    logic            m_ov;
    logic [3:0]      m_epoch;
    logic [DW-1:0]   m_k0[N];
    logic [DW-1:0]   m_k1[N];
    logic [WW+4:0]   exp_q[$];

    function automatic logic [WW-1:0] model_window(input int s);
        logic [WW-1:0] w;
        int t;
        w = '0;
        for (int e = 0; e < L; e++) begin
            t = s - (L - 1) + e;
            if (t >= 0) w[(L-1-e)*DW +: DW] = m_k0[t];
            else        w[(L-1-e)*DW +: DW] = m_k1[t + N];
        end
        return w;
    endfunction

    initial begin
        logic [WW-1:0] w_8_15, w_pf3, w_0_7, w_new, w_pf5_new;
        logic exp_rr, acc;
        int s;

        w_8_15    = pk8(8, 9, 10, 11, 12, 13, 14, 15);
        w_pf3     = pk8(28, 29, 30, 31, 0, 1, 2, 3);
        w_0_7     = pk8(0, 1, 2, 3, 4, 5, 6, 7);
        w_new     = pk8(23, 22, 21, 20, 19, 18, 17, 16);
        w_pf5_new = pk8(14, 15, 31, 30, 29, 28, 27, 26);

        //        colv pat  fl  rv  mode   inblk      pf     ordy rr  ov  win       sel ep
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,10'd0,   10'd0, 1'b0,1'b0,1'b0,'0,      1'b0,4'd0};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_8_15,  1'b0,4'd1};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b1,2'b10,10'd15,  10'd3, 1'b1,1'b1,1'b1,w_pf3,   1'b1,4'd1};
        vt[3]  = '{1'b0,1'b0,1'b0,1'b1,2'b00,10'h3F7, 10'd0, 1'b1,1'b1,1'b1,w_0_7,   1'b0,4'd1};
        vt[4]  = '{1'b0,1'b0,1'b0,1'b1,2'b11,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_8_15,  1'b0,4'd1};
        vt[5]  = '{1'b0,1'b0,1'b0,1'b0,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b0,w_8_15,  1'b0,4'd1};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_8_15,  1'b0,4'd1};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_new,   1'b0,4'd2};
        vt[8]  = '{1'b0,1'b1,1'b1,1'b0,2'b01,10'd15,  10'd0, 1'b0,1'b0,1'b0,w_new,   1'b0,4'd2};
        vt[9]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b0,1'b0,w_new,   1'b0,4'd2};
        vt[10] = '{1'b1,1'b0,1'b0,1'b0,2'b01,10'd15,  10'd0, 1'b1,1'b0,1'b0,w_new,   1'b0,4'd2};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_8_15,  1'b0,4'd3};
        vt[12] = '{1'b1,1'b1,1'b1,1'b0,2'b01,10'd15,  10'd0, 1'b0,1'b0,1'b0,w_8_15,  1'b0,4'd3};
        vt[13] = '{1'b0,1'b1,1'b0,1'b1,2'b01,10'd15,  10'd0, 1'b1,1'b1,1'b1,w_new,   1'b0,4'd4};

        // ---------- reset state ----------
        do_reset();
        @(negedge clk);
        chk("reset_req_ready", u_if.req_ready, 1'b0);
        chk("reset_out_valid", u_if.out_valid, 1'b0);
        chk("reset_out_window", u_if.out_window, '0);
        chk("reset_out_sel", u_if.out_sel, 1'b0);
        chk("reset_out_epoch", u_if.out_epoch, 4'd0);
        @(posedge clk);
        #1;

        // ---------- table-driven vectors ----------
        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            u_if.col_valid = vt[i].col_valid;
            set_cols(vt[i].col_pat);
            u_if.flush = vt[i].flush;
            u_if.req_valid = vt[i].req_valid;
            u_if.req_mode = vt[i].mode;
            u_if.in_block_x_startpoint = vt[i].inblk;
            u_if.prefetch_x_startpoint = vt[i].pf;
            u_if.out_ready = vt[i].out_ready;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", i), u_if.req_ready, vt[i].exp_rr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), u_if.out_valid, vt[i].exp_ov);
            chk($sformatf("vec%0d_out_window", i), u_if.out_window, vt[i].exp_win);
            chk($sformatf("vec%0d_out_sel", i), u_if.out_sel, vt[i].exp_sel);
            chk($sformatf("vec%0d_out_epoch", i), u_if.out_epoch, vt[i].exp_ep);
        end

        // ---------- backpressure: hold 5 cycles, then back-to-back ----------
        idle_inputs();
        u_if.req_valid = 1'b1;
        u_if.req_mode = 2'b10;
        u_if.prefetch_x_startpoint = 10'd5;
        u_if.in_block_x_startpoint = 10'd15;
        u_if.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_req_ready", u_if.req_ready, 1'b0);
            chk("stall_out_valid", u_if.out_valid, 1'b1);
            chk("stall_out_window", u_if.out_window, w_new);
            chk("stall_out_tags", {u_if.out_sel, u_if.out_epoch}, {1'b0, 4'd4});
            @(posedge clk);
            #1;
        end
        u_if.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b2b_req_ready", u_if.req_ready, 1'b1);
            chk("b2b_out_valid_pre", u_if.out_valid, 1'b1);
            @(posedge clk);
            #1;
            chk("b2b_out_valid", u_if.out_valid, 1'b1);
            chk("b2b_out_window", u_if.out_window, w_pf5_new);
            chk("b2b_out_tags", {u_if.out_sel, u_if.out_epoch}, {1'b1, 4'd4});
        end
        u_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_out_valid", u_if.out_valid, 1'b0);

        // ---------- reset mid-transfer ----------
        u_if.req_valid = 1'b1;
        u_if.req_mode = 2'b01;
        u_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", u_if.out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", u_if.out_valid, 1'b0);
        chk("async_reset_req_ready", u_if.req_ready, 1'b0);
        chk("async_reset_window", u_if.out_window, '0);
        chk("async_reset_tags", {u_if.out_sel, u_if.out_epoch}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_reset_req_ready", u_if.req_ready, 1'b0);
        chk("post_reset_out_valid", u_if.out_valid, 1'b0);

        // ---------- randomized traffic against model ----------
        do_reset();
        m_loaded = 1'b0;
        m_ov = 1'b0;
        m_epoch = 4'd0;
        for (int i = 0; i < N; i++) begin
            m_k0[i] = '0;
            m_k1[i] = '0;
        end
        exp_q.delete();

        for (int cyc = 0; cyc < 800; cyc++) begin
            u_if.col_valid = ($urandom_range(0, 9) < 2);
            u_if.flush = ($urandom_range(0, 29) == 0);
            u_if.req_valid = ($urandom_range(0, 9) < 7);
            u_if.req_mode = 2'($urandom_range(0, 3));
            u_if.in_block_x_startpoint = PW'($urandom);
            u_if.prefetch_x_startpoint = PW'($urandom);
            u_if.out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) begin
                u_if.col_k0[i*DW +: DW] = DW'($urandom);
                u_if.col_k1[i*DW +: DW] = DW'($urandom);
            end
            @(negedge clk);
            exp_rr = m_loaded && (!m_ov || u_if.out_ready) && !u_if.flush;
            chk("rand_req_ready", u_if.req_ready, exp_rr);
            chk("rand_out_valid", u_if.out_valid, m_ov);
            if (m_ov && u_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_sb_underflow", 1'b1, 1'b0);
                end else begin
                    chk("rand_window", {u_if.out_sel, u_if.out_epoch, u_if.out_window}, exp_q.pop_front());
                end
            end
            if (u_if.flush) exp_q.delete();
            acc = u_if.req_valid && exp_rr;
            if (acc) begin
                s = (u_if.req_mode == 2'b10) ? int'(u_if.prefetch_x_startpoint) % N
                                              : int'(u_if.in_block_x_startpoint) % N;
                exp_q.push_back({(u_if.req_mode == 2'b10), m_epoch, model_window(s)});
            end
            if (u_if.flush)         m_ov = 1'b0;
            else if (acc)           m_ov = 1'b1;
            else if (u_if.out_ready) m_ov = 1'b0;
            if (u_if.flush) m_loaded = 1'b0;
            if (u_if.col_valid) begin
                m_loaded = 1'b1;
                m_epoch = m_epoch + 4'd1;
                for (int i = 0; i < N; i++) begin
                    m_k0[i] = u_if.col_k0[i*DW +: DW];
                    m_k1[i] = u_if.col_k1[i*DW +: DW];
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rand_sb_leftover", exp_q.size(), m_ov ? 1 : 0);

        // ---------- report ----------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
